// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: widths, flag bit positions,
// FSM encoding and a flag-packing helper.
package alu_pkg;
    localparam int ALU_W  = 8;
    localparam int OPC_W  = 4;
    localparam int NREG   = 4;
    localparam int RIDX_W = $clog2(NREG);

    // Bit positions inside flags_q
    localparam int FLAG_Z    = 0;
    localparam int FLAG_CY   = 1;
    localparam int FLAG_SIGN = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [2:0] pack_flags(input logic z, input logic cy, input logic sign);
        logic [2:0] f;
        f            = '0;
        f[FLAG_Z]    = z;
        f[FLAG_CY]   = cy;
        f[FLAG_SIGN] = sign;
        return f;
    endfunction
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bus between the issue controller, its instruction source and the ALU.
// master = instruction source + ALU side, slave = the controller.
interface alu_issue_ctrl_if;
    import alu_pkg::*;

    logic              instr_valid;
    logic              instr_ready;
    logic [OPC_W-1:0]  instr_opcode;
    logic [RIDX_W-1:0] instr_rd;
    logic [RIDX_W-1:0] instr_rs;
    logic [ALU_W-1:0]  instr_imm;
    logic              instr_use_imm;
    logic              instr_load;
    logic              instr_wb;

    logic [ALU_W-1:0]  operand_1;
    logic [ALU_W-1:0]  operand_2;
    logic [OPC_W-1:0]  opcode;
    logic [ALU_W-1:0]  alu_out;
    logic              z_flag;
    logic              cy_flag;
    logic              sign_flag;

    logic [2:0]        flags_q;
    logic              res_valid;
    logic [ALU_W-1:0]  res_data;
    logic              busy;

    modport master (
        output instr_valid, instr_opcode, instr_rd, instr_rs, instr_imm,
               instr_use_imm, instr_load, instr_wb,
               alu_out, z_flag, cy_flag, sign_flag,
        input  instr_ready, operand_1, operand_2, opcode,
               flags_q, res_valid, res_data, busy
    );

    modport slave (
        input  instr_valid, instr_opcode, instr_rd, instr_rs, instr_imm,
               instr_use_imm, instr_load, instr_wb,
               alu_out, z_flag, cy_flag, sign_flag,
        output instr_ready, operand_1, operand_2, opcode,
               flags_q, res_valid, res_data, busy
    );
endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// NREGS x DATA_W register file: two combinational read ports, one
// synchronous write port, asynchronous clear.
module regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     ra_a,
    output logic [DATA_W-1:0] rd_a,
    input  logic [AW-1:0]     ra_b,
    output logic [DATA_W-1:0] rd_b,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd
);
    logic [NREGS-1:0][DATA_W-1:0] mem;

    // Single write port; reset clears every entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    // Reads see the pre-write value within the writing cycle
    assign rd_a = mem[ra_a];
    assign rd_b = mem[ra_b];
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 8-bit ALU: accepts one instruction at a time,
// drives registered operands/opcode, captures result and flags.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_W,  // must match the ALU width
    parameter int NREGS  = NREG
) (
    input  logic          clk,
    input  logic          rst,
    alu_issue_ctrl_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [1:0]        state;
    logic              wb_q;
    logic [AW-1:0]     rd_q;
    logic [DATA_W-1:0] op1_q, op2_q, res_q;
    logic [OPC_W-1:0]  opc_q;
    logic [2:0]        flags_r;

    logic [DATA_W-1:0] r_a, r_b;
    logic              rf_we;
    logic [AW-1:0]     rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic              accept;

    assign accept = bus.instr_valid && (state == ST_IDLE);

    // Write port mux: load immediate at accept, or ALU result at end of EXEC
    always_comb begin
        rf_we = 1'b0;
        rf_wa = rd_q;
        rf_wd = bus.alu_out;
        if (accept && bus.instr_load) begin
            rf_we = 1'b1;
            rf_wa = bus.instr_rd;
            rf_wd = bus.instr_imm;
        end else if (state == ST_EXEC && wb_q) begin
            rf_we = 1'b1;
        end
    end

    regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
        .clk  (clk),
        .rst  (rst),
        .ra_a (bus.instr_rd),
        .rd_a (r_a),
        .ra_b (bus.instr_rs),
        .rd_b (r_b),
        .we   (rf_we),
        .wa   (rf_wa),
        .wd   (rf_wd)
    );

    // FSM plus operand/result/flag registers; reset drops any in-flight op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            wb_q    <= 1'b0;
            rd_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            opc_q   <= '0;
            res_q   <= '0;
            flags_r <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    if (bus.instr_load) begin
                        res_q <= bus.instr_imm;
                        state <= ST_DONE;
                    end else begin
                        op1_q <= r_a;
                        op2_q <= bus.instr_use_imm ? bus.instr_imm : r_b;
                        opc_q <= bus.instr_opcode;
                        wb_q  <= bus.instr_wb;
                        rd_q  <= bus.instr_rd;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Flags update even when the result is not written back
                    res_q   <= bus.alu_out;
                    flags_r <= pack_flags(bus.z_flag, bus.cy_flag, bus.sign_flag);
                    state   <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.instr_ready = (state == ST_IDLE);
    assign bus.busy        = (state != ST_IDLE);
    assign bus.res_valid   = (state == ST_DONE);
    assign bus.res_data    = res_q;
    assign bus.flags_q     = flags_r;
    assign bus.operand_1   = op1_q;
    assign bus.operand_2   = op2_q;
    assign bus.opcode      = opc_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; the bench also plays the ALU.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   pulses = 0;

    logic       alu_auto = 1'b0;
    logic [7:0] model_out = 8'h00;
    logic       m_z = 1'b0, m_cy = 1'b0, m_s = 1'b0;

    alu_issue_ctrl_if intf ();

    alu_issue_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (intf.slave)
    );

    always #5 clk = ~clk;

    // ALU model: fixed response, or pass-through of operand_2
    always_comb begin
        intf.alu_out   = alu_auto ? intf.operand_2 : model_out;
        intf.z_flag    = m_z;
        intf.cy_flag   = m_cy;
        intf.sign_flag = m_s;
    end

    // Completion pulse counter
    always @(posedge clk) begin
        if (intf.res_valid) pulses <= pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Presents an instruction in IDLE and returns in the cycle after accept
    task automatic issue(input logic [3:0] opc, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [7:0] imm, input logic use_imm, input logic load,
                         input logic wb);
        int n;
        @(negedge clk);
        intf.instr_valid   = 1'b1;
        intf.instr_opcode  = opc;
        intf.instr_rd      = rd;
        intf.instr_rs      = rs;
        intf.instr_imm     = imm;
        intf.instr_use_imm = use_imm;
        intf.instr_load    = load;
        intf.instr_wb      = wb;
        n = 0;
        while (!intf.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'(n), 32'd0);
        @(posedge clk);
        @(negedge clk);
        intf.instr_valid = 1'b0;
    endtask

    // Reads R[r] through operand_1 of a no-writeback op
    task automatic read_reg(input logic [1:0] r, input logic [7:0] exp, input string tag);
        model_out = 8'h00; m_z = 0; m_cy = 0; m_s = 0;
        issue(4'h0, r, r, 8'h00, 1'b0, 1'b0, 1'b0);
        chk(tag, intf.operand_1, exp);
        @(negedge clk);
    endtask

    initial begin
        int p0;
        intf.instr_valid   = 1'b0;
        intf.instr_opcode  = '0;
        intf.instr_rd      = '0;
        intf.instr_rs      = '0;
        intf.instr_imm     = '0;
        intf.instr_use_imm = 1'b0;
        intf.instr_load    = 1'b0;
        intf.instr_wb      = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_flags", intf.flags_q, 3'b000);
        chk("rst_res_valid", intf.res_valid, 1'b0);
        chk("rst_ready", intf.instr_ready, 1'b1);
        chk("rst_op1", intf.operand_1, 8'h00);
        rst = 1'b0;

        // Load R0 = 0x15: result one cycle after accept
        issue(4'h0, 2'd0, 2'd0, 8'h15, 1'b0, 1'b1, 1'b0);
        chk("load_res_valid", intf.res_valid, 1'b1);
        chk("load_res_data", intf.res_data, 8'h15);

        // Immediate op on R0
        model_out = 8'hA0; m_s = 1; m_cy = 0; m_z = 0;
        issue(4'b0101, 2'd0, 2'd1, 8'h8B, 1'b1, 1'b0, 1'b1);
        chk("imm_op1", intf.operand_1, 8'h15);
        chk("imm_op2", intf.operand_2, 8'h8B);
        chk("imm_opcode", intf.opcode, 4'b0101);
        chk("imm_exec_valid", intf.res_valid, 1'b0);
        chk("imm_exec_busy", intf.busy, 1'b1);
        @(negedge clk);
        chk("imm_res_valid", intf.res_valid, 1'b1);
        chk("imm_res_data", intf.res_data, 8'hA0);
        chk("imm_flags", intf.flags_q, 3'b100);
        read_reg(2'd0, 8'hA0, "r0_writeback");

        // Register-register, no writeback
        issue(4'h0, 2'd1, 2'd0, 8'hFF, 1'b0, 1'b1, 1'b0);
        issue(4'h0, 2'd2, 2'd0, 8'h01, 1'b0, 1'b1, 1'b0);
        model_out = 8'h00; m_s = 0; m_cy = 1; m_z = 1;
        issue(4'b0001, 2'd1, 2'd2, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rr_op1", intf.operand_1, 8'hFF);
        chk("rr_op2", intf.operand_2, 8'h01);
        @(negedge clk);
        chk("rr_flags", intf.flags_q, 3'b011);
        chk("rr_res_data", intf.res_data, 8'h00);
        read_reg(2'd1, 8'hFF, "rr_no_wb");

        // rd == rs
        issue(4'h0, 2'd3, 2'd0, 8'h40, 1'b0, 1'b1, 1'b0);
        model_out = 8'h80; m_s = 0; m_cy = 1; m_z = 0;
        issue(4'h2, 2'd3, 2'd3, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("same_op1", intf.operand_1, 8'h40);
        chk("same_op2", intf.operand_2, 8'h40);
        @(negedge clk);
        chk("same_flags", intf.flags_q, 3'b010);

        // Load wins over use_imm; flags untouched
        issue(4'h3, 2'd2, 2'd0, 8'h5A, 1'b1, 1'b1, 1'b1);
        chk("ldimm_res_valid", intf.res_valid, 1'b1);
        chk("ldimm_res_data", intf.res_data, 8'h5A);
        chk("ldimm_flags", intf.flags_q, 3'b010);
        read_reg(2'd2, 8'h5A, "ldimm_reg");

        // Continuous valid with fields changing every cycle
        alu_auto = 1'b1; m_s = 0; m_cy = 0; m_z = 0;
        @(negedge clk);
        p0 = pulses;
        for (int k = 0; k < 9; k++) begin
            intf.instr_valid   = 1'b1;
            intf.instr_opcode  = 4'(k);
            intf.instr_rd      = 2'(k);
            intf.instr_rs      = 2'd0;
            intf.instr_imm     = 8'(8'h10 + k);
            intf.instr_use_imm = 1'b1;
            intf.instr_load    = 1'b0;
            intf.instr_wb      = 1'b0;
            chk($sformatf("hs_ready_%0d", k), intf.instr_ready, (k % 3 == 0));
            chk($sformatf("hs_valid_%0d", k), intf.res_valid, (k % 3 == 2));
            if (k % 3 == 1) begin
                chk($sformatf("hs_op2_%0d", k), intf.operand_2, 8'(8'h10 + k - 1));
                chk($sformatf("hs_opc_%0d", k), intf.opcode, 4'(k - 1));
            end
            if (k % 3 == 2)
                chk($sformatf("hs_res_%0d", k), intf.res_data, 8'(8'h10 + k - 2));
            @(negedge clk);
        end
        intf.instr_valid = 1'b0;
        chk("hs_pulses", 32'(pulses - p0), 32'd3);
        chk("hs_idle", intf.busy, 1'b0);
        alu_auto = 1'b0;

        // Reset mid-EXEC
        issue(4'h0, 2'd1, 2'd0, 8'h77, 1'b0, 1'b1, 1'b0);
        model_out = 8'h99; m_s = 1; m_cy = 1; m_z = 0;
        issue(4'h4, 2'd1, 2'd1, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("mid_exec_busy", intf.busy, 1'b1);
        p0 = pulses;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", intf.busy, 1'b0);
        chk("mid_rst_flags", intf.flags_q, 3'b000);
        chk("mid_rst_valid", intf.res_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_pulses", 32'(pulses - p0), 32'd0);
        read_reg(2'd1, 8'h00, "mid_rst_reg");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound
    initial begin
        #20000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1);
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Instruction-issue controller that sits on the driving side of the 8-bit ALU. It accepts one decoded instruction at a time over a valid/ready handshake and sources the ALU's operand_1, operand_2 and opcode from a small register file or an immediate. It captures alu_out and the z/cy/sign flags back into the register file and a flag register. It is the first sequential piece of the microprocessor datapath, and a later fetch/decode stage feeds it.

Parameters:
DATA_W, 8, datapath width; must equal ALU width (8)
NREGS, 4, register-file depth; register index width is clog2(NREGS) = 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
instr_valid  input  1  instruction present
instr_ready  output  1  controller can accept an instruction
instr_opcode  input  4  ALU opcode, passed through opaquely
instr_rd  input  2  destination register and operand_1 source
instr_rs  input  2  operand_2 source register
instr_imm  input  8  immediate value
instr_use_imm  input  1  1: operand_2 = imm
instr_load  input  1  1: R[rd] <= imm, no ALU op
instr_wb  input  1  1: write ALU result to R[rd]
operand_1  output  8  to ALU
operand_2  output  8  to ALU
opcode  output  4  to ALU
alu_out  input  8  from ALU
z_flag  input  1  from ALU
cy_flag  input  1  from ALU
sign_flag  input  1  from ALU
flags_q  output  3  registered flags {sign, cy, z}
res_valid  output  1  one-cycle completion pulse
res_data  output  8  result of the completed instruction
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, any state, including mid-instruction):
  - state = IDLE.
  - All R[i], operand_1, operand_2, opcode, flags_q, res_data cleared to 0.
  - res_valid = 0.
  - Any in-flight instruction is discarded and no writeback occurs.
- FSM states: IDLE, EXEC, DONE. instr_ready = 1 only in IDLE.
- IDLE, accept on valid & ready at edge T:
  - If instr_load = 1: R[rd] <= imm; res_data <= imm; go to DONE. Flags unchanged; ALU registers unchanged.
  - Otherwise: operand_1 <= R[rd]; operand_2 <= use_imm ? imm : R[rs]; opcode <= instr_opcode; wb and rd latched internally; go to EXEC.
- EXEC, one cycle:
  - The ALU is treated as purely combinational.
  - At edge T+1: res_data <= alu_out; flags_q <= {sign_flag, cy_flag, z_flag}; if latched wb = 1, R[rd] <= alu_out. Go to DONE.
- DONE, one cycle: res_valid = 1; go to IDLE.
- Latency:
  - ALU op: res_valid high in the cycle after edge T+1, i.e. 2 cycles after accept.
  - Load: res_valid high 1 cycle after accept.
  - Throughput: one instruction per 3 cycles (ALU) or 2 cycles (load).
- Operand registers hold their values after EXEC until the next accepted ALU instruction; the ALU inputs are therefore stable and glitch-free.
- instr_* inputs are sampled only at the accept edge; changes while busy are ignored.
- instr_valid without instr_ready (i.e. while busy): no effect. The driver must hold the instruction until accepted.
- rd == rs: operand_1 = operand_2 = R[rd], both read before writeback.
- Flags always update on an ALU op, even when wb = 0 (compare-style use).
- Load and use_imm both set: load takes priority.
- res_valid is never asserted twice for one instruction.

Decomposition:
- Shared package alu_pkg:
  - State encoding for IDLE/EXEC/DONE.
  - DATA_W, the opcode width (4), the flag bit positions (Z=0, CY=1, SIGN=2).
- Sub-module regfile (NREGS x DATA_W):
  - Two combinational read ports, one synchronous write port, asynchronous clear on rst.
  - Used by alu_issue_ctrl; the FSM and operand muxing remain in the top module.

Test Plan:
- Reset mid-EXEC: assert rst during EXEC -> state IDLE, flags_q = 000, res_valid never pulses, and a subsequent read of R[rd] via a no-wb op shows 0.
- Load then immediate op: load R0 = 0x15; then opcode 0101, rd = 0, use_imm = 1, imm = 0x8B, wb = 1, with an ALU model returning 0xA0, sign = 1, cy = 0, z = 0. Expected:
  - operand_1 = 0x15, operand_2 = 0x8B, opcode = 0101 during EXEC.
  - res_data = 0xA0, flags_q = 100.
  - R0 = 0xA0.
  - res_valid exactly 2 cycles after accept.
- Register-register op: R1 = 0xFF, R2 = 0x01, rd = 1, rs = 2, wb = 0, model returning 0x00, cy = 1, z = 1 -> flags_q = 011, res_data = 0x00, R1 still 0xFF.
- Handshake: hold instr_valid high continuously with changing fields -> instr_ready low for 2 cycles after each accept; only the values present at accept edges are used; 3 instructions complete in 9 cycles.
- rd == rs: R3 = 0x40, rd = rs = 3, use_imm = 0 -> operand_1 = operand_2 = 0x40.
- Load and use_imm both set: imm = 0x5A -> R[rd] = 0x5A, flags unchanged, res_valid 1 cycle after accept.
